// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
// Module  : lcd_reader
// Brief   : HD44780 8-bit read sequencer: status reads, DDRAM reads, busy polls
// Revision: 1.0
// ============================================================================
module lcd_reader #(
   parameter int HOLD_TIME = 500,
   parameter int MAX_POLLS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [6:0] addr,
   input  logic [7:0] lcd_db_in,
   output logic [7:0] lcd_db_out,
   output logic       lcd_db_oe,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] rd_data,
   output logic       busy_flag,
   output logic [6:0] addr_counter,
   output logic       timeout_err,
   output logic       busy,
   output logic       done_tick
);
   localparam logic [15:0] c_H      = 16'(HOLD_TIME);
   localparam logic [15:0] c_SAMPLE = 16'(2 * HOLD_TIME - 1);
   localparam logic [15:0] c_LAST   = 16'(3 * HOLD_TIME - 1);
   localparam int          c_PW     = $clog2(MAX_POLLS + 1);
   localparam logic [c_PW-1:0] c_MAXP = c_PW'(MAX_POLLS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR_WR = 3'd1,
      S_POLL    = 3'd2,
      S_STAT_RD = 3'd3,
      S_DATA_RD = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [15:0]     r_cnt;
   logic [c_PW-1:0] r_polls;
   logic            r_busy_smp;
   logic [c_PW-1:0] w_polls_inc;
   logic            w_in_phase, w_phase_end, w_sample, w_load, w_timeout;

   assign w_in_phase  = (r_state == S_ADDR_WR) || (r_state == S_POLL) ||
                        (r_state == S_STAT_RD) || (r_state == S_DATA_RD);
   assign w_phase_end = w_in_phase && (r_cnt == c_LAST);
   assign w_sample    = w_in_phase && (r_cnt == c_SAMPLE);

   assign lcd_en    = w_in_phase && (r_cnt >= c_H) && (r_cnt <= c_SAMPLE);
   assign busy      = (r_state != S_IDLE);
   assign done_tick = (r_state == S_DONE);

   // w_load marks the edge that opens a new bus phase and loads its pin values
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_timeout   = 1'b0;
      w_polls_inc = r_polls + c_PW'(1);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               case (op)
                  2'b01:   w_state_nxt = S_DATA_RD;
                  2'b10:   w_state_nxt = S_ADDR_WR;
                  default: w_state_nxt = S_STAT_RD;
               endcase
            end
         end
         S_ADDR_WR: begin
            if (w_phase_end) begin
               w_state_nxt = S_POLL;
               w_load      = 1'b1;
            end
         end
         S_POLL: begin
            if (w_phase_end) begin
               if (!r_busy_smp) begin
                  w_state_nxt = S_DATA_RD;
                  w_load      = 1'b1;
               end else if (w_polls_inc == c_MAXP) begin
                  w_state_nxt = S_DONE;
                  w_timeout   = 1'b1;
               end else begin
                  w_state_nxt = S_POLL;
                  w_load      = 1'b1;
               end
            end
         end
         S_STAT_RD, S_DATA_RD: begin
            if (w_phase_end) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 16'd0;
         r_polls      <= '0;
         r_busy_smp   <= 1'b0;
         lcd_db_out   <= 8'd0;
         lcd_db_oe    <= 1'b0;
         lcd_rs       <= 1'b0;
         lcd_rw       <= 1'b0;
         rd_data      <= 8'd0;
         busy_flag    <= 1'b0;
         addr_counter <= 7'd0;
         timeout_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (w_in_phase && !w_phase_end) ? r_cnt + 16'd1 : 16'd0;

         if (w_sample) begin
            r_busy_smp <= lcd_db_in[7];
            case (r_state)
               S_STAT_RD: begin
                  rd_data      <= lcd_db_in;
                  busy_flag    <= lcd_db_in[7];
                  addr_counter <= lcd_db_in[6:0];
               end
               S_POLL: begin
                  busy_flag    <= lcd_db_in[7];
                  addr_counter <= lcd_db_in[6:0];
               end
               S_DATA_RD: rd_data <= lcd_db_in;
               default: ;
            endcase
         end

         if (r_state == S_IDLE && start) timeout_err <= 1'b0;
         if (w_timeout) begin
            timeout_err <= 1'b1;
            rd_data     <= 8'd0;
         end

         if (r_state == S_ADDR_WR)
            r_polls <= '0;
         else if (r_state == S_POLL && w_phase_end)
            r_polls <= w_polls_inc;

         // rw drops in the same edge that oe rises, so the two never overlap
         if (w_load) begin
            case (w_state_nxt)
               S_ADDR_WR: begin
                  lcd_rs     <= 1'b0;
                  lcd_rw     <= 1'b0;
                  lcd_db_oe  <= 1'b1;
                  lcd_db_out <= {1'b1, addr};
               end
               S_DATA_RD: begin
                  lcd_rs     <= 1'b1;
                  lcd_rw     <= 1'b1;
                  lcd_db_oe  <= 1'b0;
                  lcd_db_out <= 8'd0;
               end
               default: begin
                  lcd_rs     <= 1'b0;
                  lcd_rw     <= 1'b1;
                  lcd_db_oe  <= 1'b0;
                  lcd_db_out <= 8'd0;
               end
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_lcd_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_reader
// Brief   : Directed vector bench for lcd_reader with a pin-level LCD responder
// Revision: 1.0
// ============================================================================
module tb_lcd_reader;
   logic       clk, rst, start;
   logic [1:0] op;
   logic [6:0] addr;
   logic [7:0] lcd_db_in, lcd_db_out, rd_data;
   logic       lcd_db_oe, lcd_rs, lcd_rw, lcd_en, busy_flag, timeout_err, busy, done_tick;
   logic [6:0] addr_counter;

   lcd_reader #(.HOLD_TIME(4), .MAX_POLLS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
      .lcd_db_in(lcd_db_in), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .rd_data(rd_data),
      .busy_flag(busy_flag), .addr_counter(addr_counter), .timeout_err(timeout_err),
      .busy(busy), .done_tick(done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;

   // LCD responder: first rsp_nbusy status reads report busy, then ready status
   logic       rsp_rand_en = 1'b0;
   logic [7:0] rsp_rand = 8'h00, rsp_busy = 8'h80, rsp_stat = 8'h00, rsp_data = 8'h00;
   int         rsp_nbusy = 0, stat_idx = 0;
   always_comb begin
      if (rsp_rand_en)    lcd_db_in = rsp_rand;
      else if (lcd_rs)    lcd_db_in = rsp_data;
      else if (stat_idx < rsp_nbusy) lcd_db_in = rsp_busy;
      else                lcd_db_in = rsp_stat;
   end

   int         viol = 0;
   logic       p_en = 1'b0;
   logic [10:0] p_pins = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (lcd_db_oe && lcd_rw) viol = viol + 1;
         if (lcd_en && !busy) viol = viol + 1;
         if (p_en && lcd_en && ({lcd_rs, lcd_rw, lcd_db_oe, lcd_db_out} != p_pins)) viol = viol + 1;
      end
      p_en   = lcd_en;
      p_pins = {lcd_rs, lcd_rw, lcd_db_oe, lcd_db_out};
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [1:0] op;    logic [6:0] addr;
      int nbusy;         logic [7:0] busy_v, stat_v, data_v;
      int pulse;         int lat;
      logic [7:0] rd;    logic bf; logic [6:0] ac; logic to;
      int rs0, rs1, rw0, nstat; logic [7:0] wr;
   } vec_t;

   int lat, en_rs0, en_rs1, en_rw0, en_oe, nstat;
   logic [7:0] wr_byte;
   logic prev_en;

   task automatic do_txn(input logic [1:0] o, input logic [6:0] a, input int pulse_at);
      en_rs0 = 0; en_rs1 = 0; en_rw0 = 0; en_oe = 0; nstat = 0;
      stat_idx = 0; wr_byte = 8'h00; prev_en = 1'b0;
      @(negedge clk);
      op = o; addr = a; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1;
      while (done_tick !== 1'b1 && lat < 400) begin
         if (lcd_en) begin
            if (lcd_rs) en_rs1++; else en_rs0++;
            if (!lcd_rw) begin en_rw0++; wr_byte = lcd_db_out; end
            if (lcd_db_oe) en_oe++;
         end
         if (prev_en && !lcd_en && lcd_rw && !lcd_rs) begin
            stat_idx++; nstat++;
         end
         prev_en = lcd_en;
         @(negedge clk);
         lat++;
         if (lat == pulse_at) begin start = 1'b1; op = 2'b10; addr = 7'h7F; end
         else start = 1'b0;
      end
      start = 1'b0;
      if (lat >= 400) chk("done_timeout", 0, 1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{2'b00, 7'h00, 0,   8'h00, 8'hA5, 8'h00, 0, 13, 8'hA5, 1'b1, 7'h25, 1'b0, 4,  0, 0, 1, 8'h00};
      vecs[1] = '{2'b01, 7'h00, 0,   8'h00, 8'h00, 8'h7E, 0, 13, 8'h7E, 1'b1, 7'h25, 1'b0, 0,  4, 0, 0, 8'h00};
      vecs[2] = '{2'b10, 7'h45, 2,   8'hC5, 8'h46, 8'h41, 0, 61, 8'h41, 1'b0, 7'h46, 1'b0, 16, 4, 4, 3, 8'hC5};
      vecs[3] = '{2'b10, 7'h12, 255, 8'h92, 8'h00, 8'h00, 0, 49, 8'h00, 1'b1, 7'h12, 1'b1, 16, 0, 4, 3, 8'h92};
      vecs[4] = '{2'b11, 7'h00, 0,   8'h00, 8'h3C, 8'h00, 0, 13, 8'h3C, 1'b0, 7'h3C, 1'b0, 4,  0, 0, 1, 8'h00};
      vecs[5] = '{2'b01, 7'h00, 0,   8'h00, 8'h00, 8'hFF, 0, 13, 8'hFF, 1'b0, 7'h3C, 1'b0, 0,  4, 0, 0, 8'h00};
      vecs[6] = '{2'b01, 7'h00, 0,   8'h00, 8'h00, 8'h5A, 5, 13, 8'h5A, 1'b0, 7'h3C, 1'b0, 0,  4, 0, 0, 8'h00};

      // reset with random inputs
      rst = 1'b1; rsp_rand_en = 1'b1; start = 1'b0; op = 2'b00; addr = 7'h00;
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1)); op = 2'($urandom); addr = 7'($urandom);
         rsp_rand = 8'($urandom);
      end
      @(negedge clk);
      chk("rst_db_out", lcd_db_out, 0);   chk("rst_oe", lcd_db_oe, 0);
      chk("rst_rs", lcd_rs, 0);           chk("rst_rw", lcd_rw, 0);
      chk("rst_en", lcd_en, 0);           chk("rst_rd_data", rd_data, 0);
      chk("rst_busy_flag", busy_flag, 0); chk("rst_addr_counter", addr_counter, 0);
      chk("rst_timeout", timeout_err, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done_tick, 0);
      start = 1'b0; rsp_rand_en = 1'b0;
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) begin
         rsp_nbusy = vecs[i].nbusy; rsp_busy = vecs[i].busy_v;
         rsp_stat  = vecs[i].stat_v; rsp_data = vecs[i].data_v;
         do_txn(vecs[i].op, vecs[i].addr, vecs[i].pulse);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].rd);
         chk($sformatf("v%0d_busy_flag", i), busy_flag, vecs[i].bf);
         chk($sformatf("v%0d_addr_counter", i), addr_counter, vecs[i].ac);
         chk($sformatf("v%0d_timeout_err", i), timeout_err, vecs[i].to);
         chk($sformatf("v%0d_en_rs0_cycles", i), en_rs0, vecs[i].rs0);
         chk($sformatf("v%0d_en_rs1_cycles", i), en_rs1, vecs[i].rs1);
         chk($sformatf("v%0d_en_write_cycles", i), en_rw0, vecs[i].rw0);
         chk($sformatf("v%0d_en_oe_cycles", i), en_oe, vecs[i].rw0);
         chk($sformatf("v%0d_status_reads", i), nstat, vecs[i].nstat);
         chk($sformatf("v%0d_write_byte", i), wr_byte, vecs[i].wr);
         chk($sformatf("v%0d_bus_safety", i), viol, 0);
      end

      // start in the done_tick cycle is dropped
      op = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_start_ignored_busy", busy, 0);
      chk("done_single_cycle", done_tick, 0);
      @(negedge clk);
      chk("done_start_not_queued", busy, 0);

      // reset in the middle of the enable-high window
      rsp_nbusy = 0; rsp_stat = 8'h99;
      op = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50 && !lcd_en; k++) @(negedge clk);
      chk("rst_mid_en_reached", lcd_en, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_en", lcd_en, 0);
      chk("rst_mid_oe", lcd_db_oe, 0);
      chk("rst_mid_busy", busy, 0);
      rst = 1'b0;
      rsp_stat = 8'h11;
      do_txn(2'b00, 7'h00, 0);
      chk("post_rst_latency", lat, 13);
      chk("post_rst_rd_data", rd_data, 8'h11);
      chk("post_rst_addr_counter", addr_counter, 7'h11);
      chk("post_rst_busy_flag", busy_flag, 0);
      chk("post_rst_bus_safety", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the HD44780 8-bit LCD write driver; runs on the same clock and shares the same LCD pins.
- Performs status reads (busy flag plus address counter) and DDRAM data reads, optionally preceded by a set-DDRAM-address write.
- Drives `lcd_rw` and owns the tri-state control of the data bus.
- Hands results to the CPU-side register block with a one-cycle `done_tick`.

## Interface
- `HOLD_TIME`, 500: length in clk cycles of each of the three windows of a bus phase (setup, enable-high, hold).
- `MAX_POLLS`, 16: maximum busy-flag polls after an address write before giving up.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 status read, 01 data read at current address, 10 set address then data read, 11 treated as 00.
- `addr` in 7: DDRAM address for op 10; sampled with `start`.
- `lcd_db_in` in 8: data bus as read from the pins.
- `lcd_db_out` out 8: data bus drive value.
- `lcd_db_oe` out 1: bus output enable; 1 only during write phases.
- `lcd_rs` out 1: register select.
- `lcd_rw` out 1: 1 for read phases, 0 for write phases.
- `lcd_en` out 1: LCD enable strobe.
- `rd_data` out 8: last read byte (status byte for op 00/11, DDRAM byte otherwise).
- `busy_flag` out 1: DB7 of the last status sample.
- `addr_counter` out 7: DB6:0 of the last status sample.
- `timeout_err` out 1: last transaction aborted on poll limit.
- `busy` out 1: high whenever state ≠ IDLE.
- `done_tick` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ADDR_WR, POLL, STAT_RD, DATA_RD, DONE.
- IDLE:
  - `lcd_en`=0 and `lcd_db_oe`=0; `rw`/`rs` hold their last values.
  - On `start`: op 00/11 → STAT_RD; op 01 → DATA_RD; op 10 → ADDR_WR.
  - `op` and `addr` are latched on `start`. `timeout_err` clears on `start`.
- Every bus phase has three windows, 3×HOLD_TIME cycles total, driven by a 16-bit phase counter that starts at 0:
  - setup window: counter 0..H-1, en=0;
  - enable-high window: H..2H-1, en=1;
  - hold window: 2H..3H-1, en=0.
- `rs`, `rw`, `oe` and `db_out` are set in the first setup cycle and stay constant for the whole phase.
- Read phases sample `lcd_db_in` on the last enable-high cycle (counter = 2H-1).
- ADDR_WR:
  - rs=0, rw=0, oe=1, `db_out` = {1, addr}.
  - Goes to POLL with the poll count cleared.
- POLL: rs=0, rw=1, oe=0.
  - At phase end, if sampled DB7=0 → DATA_RD.
  - Otherwise poll count +1; if count = MAX_POLLS → set `timeout_err`=1, `rd_data`=0, go to DONE (no data phase); else repeat POLL.
- STAT_RD: rs=0, rw=1, oe=0. Sample goes to `rd_data`, `busy_flag`, `addr_counter`; then DONE. The busy value is not acted on.
- DATA_RD: rs=1, rw=1, oe=0. Sample goes to `rd_data`; then DONE.
- POLL samples also update `busy_flag` and `addr_counter`.
- DONE: `done_tick`=1 for exactly one cycle, `db_out`=0, next state IDLE.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset values: all outputs 0. State → IDLE; counters and poll count → 0.
- Reset during any phase: `lcd_en` and `lcd_db_oe` are 0 on the cycle after the reset edge.
- Bus safety:
  - `lcd_db_oe` and `lcd_rw` are never 1 in the same cycle.
  - `rw`, `rs`, `oe` and `db_out` never change while `lcd_en`=1.
  - `lcd_en` is never 1 outside the enable-high window.
- Latency from the `start`-sampling edge to the `done_tick` cycle, with P = 3×HOLD_TIME:
  - op 00/01: P+1 cycles;
  - op 10 with n polls (n ≤ MAX_POLLS): (1+n+1)×P+1;
  - timeout: (1+MAX_POLLS)×P+1.
- `rd_data`, `busy_flag`, `addr_counter` and `timeout_err` are valid in the `done_tick` cycle and hold until the next `start`, except that POLL samples update the status fields mid-transaction.
- `start` arriving in the `done_tick` cycle is ignored; `start` is accepted from the following IDLE cycle.

## Test plan
Bench runs with HOLD_TIME=4 (P=12) and a pin-level LCD responder model.
- Reset check: hold `rst` 3 cycles with random inputs → every output 0; `busy`=0.
- Status read: op=00, model drives 0xA5 → `rs`=0, `rw`=1, `oe`=0 throughout; `en` high exactly 4 cycles; `rd_data`=0xA5, `busy_flag`=1, `addr_counter`=0x25; `done_tick` 13 cycles after the start edge.
- Data read: op=01, model drives 0x7E → `rs`=1, `rw`=1; `rd_data`=0x7E; `done_tick` at +13.
- Address, poll, read: op=10, addr=0x45.
  - Write phase: `db_out`=0xC5, `oe`=1, `rw`=0.
  - Model reports busy on 2 polls, then 0x46 status, then data 0x41.
  - Result: `rd_data`=0x41, `addr_counter`=0x46, `timeout_err`=0, `done_tick` at +61.
- Timeout: MAX_POLLS=3, model always drives DB7=1 → exactly 3 POLL phases, no DATA_RD; `timeout_err`=1, `rd_data`=0; `done_tick` at +49.
- Robustness:
  - `start` pulsed mid-transaction → no effect on phases or `done_tick`.
  - `rst` asserted mid enable-high window → `en`=0 and `oe`=0 next cycle; a new op 00 afterwards completes normally.
  - Assertion on every test: `oe` and `rw` never both 1.
